ysyx_exu_csr_ctrl: RTL

- Requester and writer side of the machine-mode CSR register file.
- Accepts one decoded CSR, ECALL or MRET operation per handshake from the EXU issue stage.
- Sequences the register file's read/write/trap-entry interface (wen, exu_valid, ecallen, waddr/waddr_add1, wdata/wdata_add1).
- Returns the rd writeback value and any PC redirect to the commit stage.

---
 rtl/ysyx_csr_pkg.sv | 31 +++
 rtl/ysyx_csr_alu.sv | 26 ++
 rtl/ysyx_exu_csr_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_csr_pkg.sv
// rtl/ysyx_csr_pkg.sv - shared CSR addresses, funct3 encodings, FSM states and trap cause
package ysyx_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam int CAUSE_ECALL_M = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/ysyx_csr_alu.sv
// rtl/ysyx_csr_alu.sv - new CSR value and write-suppress flag for Zicsr read-modify-write ops
module ysyx_csr_alu #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_src,
    input  logic [4:0]      i_rs1_idx,
    output logic [XLEN-1:0] o_new,
    output logic            o_suppress
);

    always_comb begin
        o_new = i_old;
        unique case (i_op[1:0])
            2'b01:   o_new = i_src;
            2'b10:   o_new = i_old | i_src;
            2'b11:   o_new = i_old & ~i_src;
            default: o_new = i_old;
        endcase
    end

    // set/clear with x0 or zimm 0 must not write, so side-effecting CSRs stay untouched
    assign o_suppress = i_op[1] && (i_rs1_idx == 5'd0);

endmodule

// File: rtl/ysyx_exu_csr_ctrl.sv
// rtl/ysyx_exu_csr_ctrl.sv - CSR op / ECALL / MRET sequencer in front of the CSR file; YSYX_CSR_BYPASS_EN skips READ
module ysyx_exu_csr_ctrl #(
    parameter int XLEN          = 32,
    parameter int CAUSE_ECALL_M = ysyx_csr_pkg::CAUSE_ECALL_M
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_ecall,
    input  logic            in_mret,
    input  logic [11:0]     in_csr,
    input  logic [4:0]      in_rs1_idx,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_pc,
    output logic [11:0]     csr_waddr,
    output logic [11:0]     csr_waddr_add1,
    output logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_wdata_add1,
    output logic            csr_wen,
    output logic            csr_ecallen,
    output logic            csr_exu_valid,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [XLEN-1:0] out_rd_wdata,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_npc,
    output logic            out_illegal
);
    import ysyx_csr_pkg::*;

    csr_state_e r_state, w_next;

    logic [2:0]      r_op;
    logic            r_ecall, r_mret, r_illegal, r_redirect;
    logic [11:0]     r_csr;
    logic [4:0]      r_rs1_idx, r_rd;
    logic [XLEN-1:0] r_rs1_val, r_pc, r_old, r_new, r_npc;

    logic [2:0]      w_alu_op;
    logic [4:0]      w_alu_idx;
    logic [XLEN-1:0] w_alu_val, w_src, w_new;
    logic [11:0]     w_alu_csr;
    logic            w_suppress, w_ro, w_do_write, w_illegal, w_accept;

`ifdef YSYX_CSR_BYPASS_EN
    assign w_alu_op  = in_op;
    assign w_alu_idx = in_rs1_idx;
    assign w_alu_val = in_rs1_val;
    assign w_alu_csr = in_csr;
`else
    assign w_alu_op  = r_op;
    assign w_alu_idx = r_rs1_idx;
    assign w_alu_val = r_rs1_val;
    assign w_alu_csr = r_csr;
`endif

    assign w_src      = w_alu_op[2] ? {{(XLEN-5){1'b0}}, w_alu_idx} : w_alu_val;
    assign w_ro       = csr_is_ro(w_alu_csr);
    assign w_do_write = !w_suppress && !w_ro;
    assign w_illegal  = w_ro && !w_suppress;
    assign w_accept   = (r_state == ST_IDLE) && in_valid;

    ysyx_csr_alu #(.XLEN(XLEN)) u_alu (
        .i_op       (w_alu_op),
        .i_old      (csr_rdata),
        .i_src      (w_src),
        .i_rs1_idx  (w_alu_idx),
        .o_new      (w_new),
        .o_suppress (w_suppress)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        in_ready       = 1'b0;
        csr_waddr      = '0;
        csr_waddr_add1 = '0;
        csr_wdata      = '0;
        csr_wdata_add1 = '0;
        csr_wen        = 1'b0;
        csr_ecallen    = 1'b0;
        csr_exu_valid  = 1'b0;
        out_valid      = 1'b0;
        out_rd         = '0;
        out_rd_wen     = 1'b0;
        out_rd_wdata   = '0;
        out_redirect   = 1'b0;
        out_npc        = '0;
        out_illegal    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
`ifdef YSYX_CSR_BYPASS_EN
                if (in_valid) csr_waddr = in_csr;
`endif
                if (in_valid) begin
                    if (in_ecall)     w_next = ST_WRITE;
                    else if (in_mret) w_next = ST_RESP;
`ifdef YSYX_CSR_BYPASS_EN
                    else              w_next = w_do_write ? ST_WRITE : ST_RESP;
`else
                    else              w_next = ST_READ;
`endif
                end
            end
            ST_READ: begin
                csr_waddr = r_csr;
                w_next    = w_do_write ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                csr_wen       = 1'b1;
                csr_exu_valid = 1'b1;
                if (r_ecall) begin
                    csr_ecallen    = 1'b1;
                    csr_waddr      = CSR_MEPC;
                    csr_wdata      = r_pc;
                    csr_waddr_add1 = CSR_MCAUSE;
                    csr_wdata_add1 = XLEN'(CAUSE_ECALL_M);
                end else begin
                    csr_waddr      = r_csr;
                    csr_wdata      = r_new;
                    csr_waddr_add1 = r_csr;
                    csr_wdata_add1 = r_new;
                end
                w_next = ST_RESP;
            end
            ST_RESP: begin
                out_valid    = 1'b1;
                out_rd       = r_rd;
                out_rd_wen   = (r_rd != 5'd0) && !r_ecall && !r_mret && !r_illegal;
                out_rd_wdata = r_old;
                out_redirect = r_redirect;
                out_npc      = r_npc;
                out_illegal  = r_illegal;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op       <= '0;
            r_ecall    <= 1'b0;
            r_mret     <= 1'b0;
            r_csr      <= '0;
            r_rs1_idx  <= '0;
            r_rs1_val  <= '0;
            r_rd       <= '0;
            r_pc       <= '0;
            r_old      <= '0;
            r_new      <= '0;
            r_illegal  <= 1'b0;
            r_redirect <= 1'b0;
            r_npc      <= '0;
        end else if (w_accept) begin
            r_op       <= in_op;
            r_ecall    <= in_ecall;
            r_mret     <= in_mret && !in_ecall;
            r_csr      <= in_csr;
            r_rs1_idx  <= in_rs1_idx;
            r_rs1_val  <= in_rs1_val;
            r_rd       <= in_rd;
            r_pc       <= in_pc;
            r_old      <= '0;
            r_new      <= '0;
            r_illegal  <= 1'b0;
            r_redirect <= in_mret && !in_ecall;
            r_npc      <= (in_mret && !in_ecall) ? csr_mepc : '0;
`ifdef YSYX_CSR_BYPASS_EN
            if (!in_ecall && !in_mret) begin
                r_old     <= csr_rdata;
                r_new     <= w_new;
                r_illegal <= w_illegal;
            end
`endif
        end else if (r_state == ST_READ) begin
            r_old     <= csr_rdata;
            r_new     <= w_new;
            r_illegal <= w_illegal;
        end else if (r_state == ST_WRITE && r_ecall) begin
            // trap target follows mtvec as seen during the trap-entry write
            r_redirect <= 1'b1;
            r_npc      <= csr_mtvec;
        end
    end

endmodule
